// File: rtl/cpu1_jtag_scan_pkg.sv
// Shared types and constants for the cpu1 virtual-JTAG scan master.
package cpu1_jtag_scan_pkg;

  localparam int SR_WIDTH = 38;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SHIFT,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } scan_state_t;

  // Zero or an over-long request scans the full register.
  function automatic logic [5:0] eff_len(input logic [5:0] len, input int unsigned sr_w);
    logic [31:0] w;
    w = sr_w;
    if (len == 6'd0 || {26'd0, len} > w) return w[5:0];
    return len;
  endfunction

endpackage

// File: rtl/cpu1_jtag_scan_if.sv
// Command/response handshake bundle between a host and the scan master.
interface cpu1_jtag_scan_if #(
  parameter int SR_WIDTH = 38
) ();
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic [5:0]          cmd_len;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [SR_WIDTH-1:0] rsp_data;
  logic [1:0]          rsp_ir;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir
  );
endinterface

// File: rtl/cpu1_jtag_scan_tck_gen.sv
// tck generator: TCK_DIV clk cycles per half period, low half first.
// sample_stb marks the cycle before tck rises, fall_stb the cycle tck falls after.
module cpu1_jtag_scan_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic sample_stb,
  output logic fall_stb
);
  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] hcnt;
  logic          half_end;

  assign half_end = (hcnt == CW'(TCK_DIV - 1));

  // Disabled means parked low with a fresh phase, so every scan starts on a low half.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      tck  <= 1'b0;
    end else if (!en) begin
      hcnt <= '0;
      tck  <= 1'b0;
    end else if (half_end) begin
      hcnt <= '0;
      tck  <= ~tck;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign sample_stb = en & ~tck & half_end;
  assign fall_stb   = en &  tck & half_end;

endmodule

// File: rtl/cpu1_jtag_scan_master.sv
// Host-side virtual-JTAG scan master for the cpu1 debug module.
// Optional build macro: CPU1_JTAG_SCAN_IR_CACHE_EN skips UIR when the IR is unchanged.
module cpu1_jtag_scan_master
  import cpu1_jtag_scan_pkg::*;
#(
  parameter int TCK_DIV  = 2,
  parameter int SR_WIDTH = cpu1_jtag_scan_pkg::SR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  cpu1_jtag_scan_if.slave  bus,
  output logic             tck,
  output logic             tdi,
  input  logic             tdo,
  output logic [1:0]       ir_in,
  input  logic [1:0]       ir_out,
  output logic             vs_uir,
  output logic             vs_cdr,
  output logic             vs_sdr,
  output logic             vs_udr,
  output logic             jtag_state_rti
);

  scan_state_t         state, state_n;
  logic [5:0]          len_q, bit_q;
  logic [SR_WIDTH-1:0] data_q, cap_q;
  logic [1:0]          ir_q, rsp_ir_q;
  logic                tdi_q;
  logic                tck_en, sample_stb, fall_stb;
  logic                accept, last_bit, ir_skip;

  assign tck_en   = (state != ST_IDLE) && (state != ST_RESP);
  assign accept   = (state == ST_IDLE) && bus.cmd_valid;
  assign last_bit = (bit_q == len_q - 6'd1);

`ifdef CPU1_JTAG_SCAN_IR_CACHE_EN
  logic cache_vld;
  assign ir_skip = cache_vld && (bus.cmd_ir == ir_q);
`else
  assign ir_skip = 1'b0;
`endif

  cpu1_jtag_scan_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk        (clk),
    .reset      (reset),
    .en         (tck_en),
    .tck        (tck),
    .sample_stb (sample_stb),
    .fall_stb   (fall_stb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    bus.cmd_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    vs_uir         = 1'b0;
    vs_cdr         = 1'b0;
    vs_sdr         = 1'b0;
    vs_udr         = 1'b0;
    jtag_state_rti = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_n = ir_skip ? ST_CDR : ST_UIR;
      end
      ST_UIR: begin
        vs_uir = 1'b1;
        if (fall_stb) state_n = ST_CDR;
      end
      ST_CDR: begin
        vs_cdr = 1'b1;
        if (fall_stb) state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        vs_sdr = 1'b1;
        if (fall_stb && last_bit) state_n = ST_UDR;
      end
      ST_UDR: begin
        vs_udr = 1'b1;
        if (fall_stb) state_n = ST_RTI;
      end
      ST_RTI: begin
        jtag_state_rti = 1'b1;
        if (fall_stb) state_n = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // data_q is consumed LSB first; tdi is loaded at each period start of SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      cap_q     <= '0;
      ir_q      <= '0;
      rsp_ir_q  <= '0;
      tdi_q     <= 1'b0;
`ifdef CPU1_JTAG_SCAN_IR_CACHE_EN
      cache_vld <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          ir_q   <= bus.cmd_ir;
          data_q <= bus.cmd_data;
          len_q  <= eff_len(bus.cmd_len, SR_WIDTH);
          cap_q  <= '0;
          bit_q  <= '0;
        end
        ST_UIR: begin
          if (sample_stb) rsp_ir_q <= ir_out;
`ifdef CPU1_JTAG_SCAN_IR_CACHE_EN
          if (fall_stb) cache_vld <= 1'b1;
`endif
        end
        ST_CDR: if (fall_stb) begin
          tdi_q  <= data_q[0];
          data_q <= data_q >> 1;
        end
        ST_SHIFT: begin
          if (sample_stb) cap_q[bit_q] <= tdo;
          if (fall_stb) begin
            tdi_q  <= last_bit ? 1'b0 : data_q[0];
            data_q <= data_q >> 1;
            bit_q  <= bit_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tdi          = tdi_q;
  assign ir_in        = ir_q;
  assign bus.rsp_data = cap_q;
  assign bus.rsp_ir   = rsp_ir_q;

endmodule

// File: tb/tb_cpu1_jtag_scan_master.sv
// Randomized self-checking bench for cpu1_jtag_scan_master against a transaction-level model.
module tb_cpu1_jtag_scan_master;
  import cpu1_jtag_scan_pkg::*;

  localparam int TCK_DIV = 2;
  localparam int SRW     = 38;
  localparam int P       = 2 * TCK_DIV;
`ifdef CPU1_JTAG_SCAN_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu1_jtag_scan_if #(.SR_WIDTH(SRW)) bus ();

  logic       tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, rti;
  logic [1:0] ir_in, ir_out;

  cpu1_jtag_scan_master #(.TCK_DIV(TCK_DIV), .SR_WIDTH(SRW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .tck            (tck),
    .tdi            (tdi),
    .tdo            (tdo),
    .ir_in          (ir_in),
    .ir_out         (ir_out),
    .vs_uir         (vs_uir),
    .vs_cdr         (vs_cdr),
    .vs_sdr         (vs_sdr),
    .vs_udr         (vs_udr),
    .jtag_state_rti (rti)
  );

  // Target stand-in: 0 = tdo follows tdi, 1 = tdi delayed one tck, 2 = inverted tdi.
  int   tdo_mode;
  logic lb = 1'b0;
  always @(posedge tck) lb <= tdi;
  always_comb begin
    case (tdo_mode)
      1:       tdo = lb;
      2:       tdo = ~tdi;
      default: tdo = tdi;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model state for the optional IR cache.
  bit         cvld = 1'b0;
  logic [1:0] last_ir, last_iro;

  task automatic run_cmd(input logic [1:0] ir, input logic [SRW-1:0] data, input logic [5:0] len,
                         input int mode, input logic [1:0] iro, input int hold);
    int L, exp_lat, n, k, bad_oh, bad_tck, bad_ir, bad_tdi, bad_seq, bad_hold, code;
    bit hit;
    logic [SRW-1:0] mask, exp_data, snap;
    int rc[$], rl[$], ec[$], el[$];
    L        = (len == 0 || len > SRW) ? SRW : int'(len);
    mask     = (L == SRW) ? {SRW{1'b1}} : ((SRW'(1) << L) - SRW'(1));
    exp_data = (mode == 1) ? ((data << 1) & mask) : (mode == 2) ? (~data & mask) : (data & mask);
    hit      = CACHE && cvld && (ir == last_ir);
    exp_lat  = (4 + L) * P + 1 - (hit ? P : 0);
    if (!hit) begin ec.push_back(0); el.push_back(P); end
    ec.push_back(1); el.push_back(P);
    ec.push_back(2); el.push_back(L * P);
    ec.push_back(3); el.push_back(P);
    ec.push_back(4); el.push_back(P);

    @(negedge clk);
    tdo_mode     = mode;
    ir_out       = iro;
    bus.cmd_ir   = ir;
    bus.cmd_data = data;
    bus.cmd_len  = len;
    bus.cmd_valid = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 100) begin @(negedge clk); k++; end
    chk("ready_wait", k, 0);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 1; bad_oh = 0; bad_tck = 0; bad_ir = 0; bad_tdi = 0;
    while (!bus.rsp_valid && n < 2000) begin
      case ({vs_uir, vs_cdr, vs_sdr, vs_udr, rti})
        5'b10000: code = 0;
        5'b01000: code = 1;
        5'b00100: code = 2;
        5'b00010: code = 3;
        5'b00001: code = 4;
        default:  begin code = -1; bad_oh++; end
      endcase
      if (rc.size() > 0 && rc[rc.size()-1] == code) rl[rl.size()-1] = rl[rl.size()-1] + 1;
      else begin rc.push_back(code); rl.push_back(1); end
      if (tck !== (((n - 1) % P) >= TCK_DIV)) bad_tck++;
      if (vs_uir && ir_in !== ir) bad_ir++;
      if (!vs_sdr && tdi !== 1'b0) bad_tdi++;
      @(negedge clk);
      n++;
    end
    chk("latency", n, exp_lat);
    chk("onehot", bad_oh, 0);
    chk("tck_shape", bad_tck, 0);
    chk("ir_in", bad_ir, 0);
    chk("tdi_idle", bad_tdi, 0);
    chk("run_cnt", rc.size(), ec.size());
    bad_seq = 0;
    for (int i = 0; i < rc.size() && i < ec.size(); i++)
      if (rc[i] != ec[i] || rl[i] != el[i]) bad_seq++;
    chk("strobe_seq", bad_seq, 0);
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("rsp_ir", bus.rsp_ir, hit ? last_iro : iro);
    if (!hit) begin cvld = 1'b1; last_ir = ir; last_iro = iro; end

    // Hold the response off with a new command pending.
    snap = bus.rsp_data;
    bad_hold = 0;
    if (hold > 0) begin
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== snap) bad_hold++;
      end
      chk("hold_stable", bad_hold, 0);
      bus.cmd_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    chk("ready_in_resp", bus.cmd_ready, 1'b0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_hs", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
  endtask

  initial begin
    logic [63:0] r;
    logic [SRW-1:0] d;
    logic [1:0] ir;
    logic [5:0] len;
    int n;
    tdo_mode      = 0;
    ir_out        = 2'b00;
    bus.cmd_valid = 1'b0;
    bus.cmd_ir    = 2'b00;
    bus.cmd_data  = '0;
    bus.cmd_len   = '0;
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {bus.cmd_ready, bus.rsp_valid, tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, rti,
                       ir_in, bus.rsp_ir}, {1'b1, 12'b0});
    chk("reset_rsp_data", bus.rsp_data, 0);
    reset = 1'b0;

    // Loopback delayed one tck, full length, latency 169 at TCK_DIV=2.
    run_cmd(IR_BREAK, 38'h2A_5A5A_5A5A, 6'd38, 1, 2'b11, 20);
    d = 38'h15_A5A5_A5A5;
    run_cmd(IR_OCIMEM, d, 6'd0, 0, 2'b11, 0);
    run_cmd(IR_TRACECTRL, d, 6'd63, 0, 2'b10, 0);
    run_cmd(IR_TRACEMEM, 38'h16, 6'd5, 0, 2'b11, 0);

    // Reset in the middle of SHIFT bit 10.
    @(negedge clk);
    tdo_mode = 0; bus.cmd_ir = IR_OCIMEM; bus.cmd_data = {SRW{1'b1}}; bus.cmd_len = 6'd38;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 1;
    while (n < 1 + 12 * P + 1) begin @(negedge clk); n++; end
    chk("mid_sdr", vs_sdr, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_outs", {bus.cmd_ready, bus.rsp_valid, tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, rti,
                        ir_in, bus.rsp_ir}, {1'b1, 12'b0});
    chk("midrst_rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    reset = 1'b0;
    cvld = 1'b0;
    run_cmd(IR_BREAK, 38'h3_0F0F_0F0F, 6'd20, 0, 2'b01, 0);

    // Same IR twice: UIR skipped on the second when the cache is built in.
    run_cmd(IR_TRACEMEM, 38'h1234, 6'd16, 0, 2'b10, 0);
    run_cmd(IR_TRACEMEM, 38'h0ABC, 6'd12, 2, 2'b01, 0);

    for (int i = 0; i < 12; i++) begin
      r   = {$urandom(), $urandom()};
      d   = r[SRW-1:0];
      ir  = 2'($urandom_range(0, 3));
      len = 6'($urandom_range(0, 63));
      run_cmd(ir, d, len, $urandom_range(0, 2), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
